spectrum_peak_search: RTL and testbench



---
 rtl/spectrum_peak_search_pkg.sv | 18 +
 rtl/spectrum_peak_search_peak_tracker.sv | 106 ++++++++++
 rtl/spectrum_peak_search.sv | 177 +++++++++++++++++
 tb/tb_spectrum_peak_search.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_peak_search_pkg.sv
// Shared definitions for the spectrum peak search stage: default widths,
// profile geometry and the controller state encoding.
package spectrum_peak_search_pkg;

    localparam int SPS_DATA_W  = 32;
    localparam int SPS_NBINS   = 512;
    localparam int SPS_BIN_W   = 9;
    localparam int SPS_NGATES  = 64;
    localparam int SPS_GATE_W  = 6;
    localparam int SPS_SKIP_LO = 4;

    // Controller states; kept as plain constants so older code can compare raw codes.
    typedef logic [1:0] sps_state_t;
    localparam sps_state_t ST_IDLE   = 2'd0;
    localparam sps_state_t ST_SEARCH = 2'd1;
    localparam sps_state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/spectrum_peak_search_peak_tracker.sv
// Per-gate maximum tracker. Holds the running maximum, its bin index, the
// sample just below it and the sample just above it. The *_nxt outputs show
// the values including the current sample, so the owner can capture a
// complete gate result on the same edge that accepts the last bin.
module spectrum_peak_search_peak_tracker
    import spectrum_peak_search_pkg::*;
#(
    parameter int DATA_W  = SPS_DATA_W,
    parameter int NBINS   = SPS_NBINS,
    parameter int BIN_W   = SPS_BIN_W,
    parameter int SKIP_LO = SPS_SKIP_LO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic [BIN_W-1:0]  bin,
    input  logic              valid,
    input  logic              clear,
    output logic [DATA_W-1:0] max_nxt,
    output logic [BIN_W-1:0]  index_nxt,
    output logic [DATA_W-1:0] left_nxt,
    output logic [DATA_W-1:0] right_nxt
);

    logic [DATA_W-1:0] max_r, left_r, right_r, prev_r;
    logic [BIN_W-1:0]  index_r;
    logic              pend_r;

    logic [DATA_W-1:0] max_s, left_s, right_s, prev_s;
    logic [BIN_W-1:0]  index_s;
    logic              pend_s;
    logic              cand_s, first_s, load_s;

    // Single compare-and-load: decide whether this sample becomes the new peak.
    always_comb begin
        cand_s  = (bin >= BIN_W'(SKIP_LO));
        first_s = (bin == BIN_W'(SKIP_LO));
        load_s  = valid & cand_s & (first_s | (sample > max_r));

        max_s   = max_r;
        index_s = index_r;
        left_s  = left_r;
        right_s = right_r;
        pend_s  = pend_r;

        if (load_s) begin
            max_s   = sample;
            index_s = bin;
            right_s = {DATA_W{1'b0}};
            if (bin == {BIN_W{1'b0}}) begin
                left_s = {DATA_W{1'b0}};
            end else begin
                left_s = prev_r;
            end
            // A peak on the top bin has no upper neighbour to wait for.
            if (bin == BIN_W'(NBINS - 1)) begin
                pend_s = 1'b0;
            end else begin
                pend_s = 1'b1;
            end
        end else if (valid & pend_r) begin
            right_s = sample;
            pend_s  = 1'b0;
        end else begin
            pend_s = pend_r;
        end

        if (valid) begin
            prev_s = sample;
        end else begin
            prev_s = prev_r;
        end
    end

    // Working registers; cleared between gates and whenever the search is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_r   <= {DATA_W{1'b0}};
            index_r <= {BIN_W{1'b0}};
            left_r  <= {DATA_W{1'b0}};
            right_r <= {DATA_W{1'b0}};
            prev_r  <= {DATA_W{1'b0}};
            pend_r  <= 1'b0;
        end else if (clear) begin
            max_r   <= {DATA_W{1'b0}};
            index_r <= {BIN_W{1'b0}};
            left_r  <= {DATA_W{1'b0}};
            right_r <= {DATA_W{1'b0}};
            prev_r  <= {DATA_W{1'b0}};
            pend_r  <= 1'b0;
        end else begin
            max_r   <= max_s;
            index_r <= index_s;
            left_r  <= left_s;
            right_r <= right_s;
            prev_r  <= prev_s;
            pend_r  <= pend_s;
        end
    end

    assign max_nxt   = max_s;
    assign index_nxt = index_s;
    assign left_nxt  = left_s;
    assign right_nxt = right_s;

endmodule

// File: rtl/spectrum_peak_search.sv
// Spectrum peak search: per range gate, finds the strongest FFT bin and
// reports its value, index and both neighbours; pulses search_done after
// the last gate of the profile.
module spectrum_peak_search
    import spectrum_peak_search_pkg::*;
#(
    parameter int DATA_W  = SPS_DATA_W,
    parameter int NBINS   = SPS_NBINS,
    parameter int BIN_W   = SPS_BIN_W,
    parameter int NGATES  = SPS_NGATES,
    parameter int GATE_W  = SPS_GATE_W,
    parameter int SKIP_LO = SPS_SKIP_LO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pp_ctrl,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              peak_valid,
    output logic [GATE_W-1:0] peak_gate,
    output logic [BIN_W-1:0]  peak_index,
    output logic [DATA_W-1:0] peak_value,
    output logic [DATA_W-1:0] peak_left,
    output logic [DATA_W-1:0] peak_right,
    output logic              search_busy,
    output logic              search_done
);

    sps_state_t        state_r, state_s;
    logic [BIN_W-1:0]  bin_cnt_r, bin_cnt_s;
    logic [GATE_W-1:0] gate_cnt_r, gate_cnt_s;

    logic accept_s, last_bin_s, last_gate_s, gate_end_s, prof_end_s, trk_clear_s;

    logic [DATA_W-1:0] trk_max_s, trk_left_s, trk_right_s;
    logic [BIN_W-1:0]  trk_index_s;

    logic              peak_valid_r, search_busy_r, search_done_r;
    logic [GATE_W-1:0] peak_gate_r;
    logic [BIN_W-1:0]  peak_index_r;
    logic [DATA_W-1:0] peak_value_r, peak_left_r, peak_right_r;

    // Sample acceptance and gate/profile boundary detection.
    always_comb begin
        accept_s    = (state_r == ST_SEARCH) & pp_ctrl & data_valid_in;
        last_bin_s  = (bin_cnt_r == BIN_W'(NBINS - 1));
        last_gate_s = (gate_cnt_r == GATE_W'(NGATES - 1));
        gate_end_s  = accept_s & last_bin_s;
        prof_end_s  = gate_end_s & last_gate_s;
        trk_clear_s = (state_r != ST_SEARCH) | gate_end_s;
    end

    // Controller next state and bin/gate counters.
    always_comb begin
        state_s    = state_r;
        bin_cnt_s  = bin_cnt_r;
        gate_cnt_s = gate_cnt_r;
        case (state_r)
            ST_IDLE: begin
                bin_cnt_s  = {BIN_W{1'b0}};
                gate_cnt_s = {GATE_W{1'b0}};
                if (pp_ctrl) begin
                    state_s = ST_SEARCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (!pp_ctrl) begin
                    // Abort: the partial gate is dropped silently.
                    state_s    = ST_IDLE;
                    bin_cnt_s  = {BIN_W{1'b0}};
                    gate_cnt_s = {GATE_W{1'b0}};
                end else if (accept_s) begin
                    if (last_bin_s) begin
                        bin_cnt_s  = {BIN_W{1'b0}};
                        gate_cnt_s = gate_cnt_r + GATE_W'(1);
                        if (last_gate_s) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_SEARCH;
                        end
                    end else begin
                        bin_cnt_s = bin_cnt_r + BIN_W'(1);
                    end
                end else begin
                    state_s = ST_SEARCH;
                end
            end
            ST_DONE: begin
                if (!pp_ctrl) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                bin_cnt_s  = {BIN_W{1'b0}};
                gate_cnt_s = {GATE_W{1'b0}};
            end
        endcase
    end

    // Controller state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bin_cnt_r  <= {BIN_W{1'b0}};
            gate_cnt_r <= {GATE_W{1'b0}};
        end else begin
            state_r    <= state_s;
            bin_cnt_r  <= bin_cnt_s;
            gate_cnt_r <= gate_cnt_s;
        end
    end

    spectrum_peak_search_peak_tracker #(
        .DATA_W  (DATA_W),
        .NBINS   (NBINS),
        .BIN_W   (BIN_W),
        .SKIP_LO (SKIP_LO)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample    (data_in),
        .bin       (bin_cnt_r),
        .valid     (accept_s),
        .clear     (trk_clear_s),
        .max_nxt   (trk_max_s),
        .index_nxt (trk_index_s),
        .left_nxt  (trk_left_s),
        .right_nxt (trk_right_s)
    );

    // Result registers: capture on the last bin, hold until the next gate ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_valid_r  <= 1'b0;
            peak_gate_r   <= {GATE_W{1'b0}};
            peak_index_r  <= {BIN_W{1'b0}};
            peak_value_r  <= {DATA_W{1'b0}};
            peak_left_r   <= {DATA_W{1'b0}};
            peak_right_r  <= {DATA_W{1'b0}};
            search_done_r <= 1'b0;
            search_busy_r <= 1'b0;
        end else begin
            peak_valid_r  <= gate_end_s;
            search_done_r <= prof_end_s;
            // Busy covers the whole search plus the cycle of the final result.
            search_busy_r <= (state_s == ST_SEARCH) | prof_end_s;
            if (gate_end_s) begin
                peak_gate_r  <= gate_cnt_r;
                peak_index_r <= trk_index_s;
                peak_value_r <= trk_max_s;
                peak_left_r  <= trk_left_s;
                peak_right_r <= trk_right_s;
            end else begin
                peak_gate_r  <= peak_gate_r;
                peak_index_r <= peak_index_r;
                peak_value_r <= peak_value_r;
                peak_left_r  <= peak_left_r;
                peak_right_r <= peak_right_r;
            end
        end
    end

    assign peak_valid  = peak_valid_r;
    assign peak_gate   = peak_gate_r;
    assign peak_index  = peak_index_r;
    assign peak_value  = peak_value_r;
    assign peak_left   = peak_left_r;
    assign peak_right  = peak_right_r;
    assign search_busy = search_busy_r;
    assign search_done = search_done_r;

endmodule

// File: tb/tb_spectrum_peak_search.sv
// Bench for spectrum_peak_search with a small geometry (8 bins, 2 gates).
module tb_spectrum_peak_search;

    localparam int DATA_W  = 32;
    localparam int NBINS   = 8;
    localparam int BIN_W   = 3;
    localparam int NGATES  = 2;
    localparam int GATE_W  = 1;
    localparam int SKIP_LO = 1;

    typedef logic [DATA_W-1:0] gate_t [NBINS];
    typedef struct {
        int              cyc;
        int              gate;
        int              idx;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        logic            done;
        logic            busy;
    } pv_rec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pp_ctrl = 1'b0;
    logic              data_valid_in = 1'b0;
    logic [DATA_W-1:0] data_in = 32'd0;
    logic              peak_valid;
    logic [GATE_W-1:0] peak_gate;
    logic [BIN_W-1:0]  peak_index;
    logic [DATA_W-1:0] peak_value;
    logic [DATA_W-1:0] peak_left;
    logic [DATA_W-1:0] peak_right;
    logic              search_busy;
    logic              search_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    pv_rec_t pv_q[$];

    spectrum_peak_search #(
        .DATA_W(DATA_W), .NBINS(NBINS), .BIN_W(BIN_W),
        .NGATES(NGATES), .GATE_W(GATE_W), .SKIP_LO(SKIP_LO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pp_ctrl(pp_ctrl),
        .data_valid_in(data_valid_in), .data_in(data_in),
        .peak_valid(peak_valid), .peak_gate(peak_gate), .peak_index(peak_index),
        .peak_value(peak_value), .peak_left(peak_left), .peak_right(peak_right),
        .search_busy(search_busy), .search_done(search_done)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp results.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every result strobe and count done pulses.
    always @(negedge clk) begin
        if (peak_valid)
            pv_q.push_back('{cyc: cyc, gate: int'(peak_gate), idx: int'(peak_index),
                             val: peak_value, left: peak_left, right: peak_right,
                             done: search_done, busy: search_busy});
        if (search_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: strongest bin at or above SKIP_LO, first occurrence wins.
    function automatic void ref_peak(input gate_t g, output int idx,
                                     output logic [DATA_W-1:0] v, l, r);
        idx = SKIP_LO;
        for (int b = SKIP_LO + 1; b < NBINS; b++)
            if (g[b] > g[idx]) idx = b;
        v = g[idx];
        l = (idx == 0) ? 32'd0 : g[idx-1];
        r = (idx == NBINS - 1) ? 32'd0 : g[idx+1];
    endfunction

    task automatic check_rec(input string tag, input pv_rec_t rec, input gate_t g, input int gate);
        int idx;
        logic [DATA_W-1:0] v, l, r;
        ref_peak(g, idx, v, l, r);
        check({tag, ".gate"},  64'(rec.gate), 64'(gate));
        check({tag, ".index"}, 64'(rec.idx),  64'(idx));
        check({tag, ".value"}, 64'(rec.val),  64'(v));
        check({tag, ".left"},  64'(rec.left), 64'(l));
        check({tag, ".right"}, 64'(rec.right), 64'(r));
    endtask

    task automatic go_idle();
        @(negedge clk);
        pp_ctrl = 1'b0;
        data_valid_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Raise pp_ctrl with a junk strobe that must be ignored; returns cycle stamp.
    task automatic start_profile(input string tag, output int t0);
        @(negedge clk);
        pp_ctrl = 1'b1;
        data_valid_in = 1'b1;
        data_in = 32'hFFFF_FFFF;
        @(negedge clk);
        data_valid_in = 1'b0;
        t0 = cyc;
        check({tag, ".busy_on_entry"}, 64'(search_busy), 64'(1));
    endtask

    task automatic drive_gate(input gate_t g, input int nb, input int gap_bin,
                              input int gap_len, output int acc);
        acc = -1;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            data_valid_in = 1'b1;
            data_in = g[b];
            if (b == NBINS - 1) acc = cyc + 1;
            if (b == gap_bin) begin
                for (int k = 0; k < gap_len; k++) begin
                    @(negedge clk);
                    data_valid_in = 1'b0;
                    data_in = $urandom;
                end
            end
        end
    endtask

    task automatic stop_data();
        @(negedge clk);
        data_valid_in = 1'b0;
    endtask

    task automatic wait_pv(input string tag, input int want);
        int budget = 200;
        while (pv_q.size() < want && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        check({tag, ".arrived"}, 64'(pv_q.size() >= want), 64'(1));
    endtask

    function automatic gate_t rand_gate();
        gate_t g;
        for (int b = 0; b < NBINS; b++)
            g[b] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
        return g;
    endfunction

    initial begin
        gate_t ga, gb, g0, g1;
        int acc0, acc1, t0, lat_a, base, dbase;
        int idx;
        logic [DATA_W-1:0] v, l, r;
        ga = '{32'd50, 32'd3, 32'd9, 32'd4, 32'd9, 32'd2, 32'd1, 32'd0};
        gb = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd70};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.peak_valid", 64'(peak_valid), 64'(0));
        check("rst.peak_gate",  64'(peak_gate),  64'(0));
        check("rst.peak_index", 64'(peak_index), 64'(0));
        check("rst.peak_value", 64'(peak_value), 64'(0));
        check("rst.peak_left",  64'(peak_left),  64'(0));
        check("rst.peak_right", 64'(peak_right), 64'(0));
        check("rst.busy",       64'(search_busy), 64'(0));
        check("rst.done",       64'(search_done), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed back-to-back profile
        base = pv_q.size(); dbase = done_cnt;
        start_profile("dir", t0);
        drive_gate(ga, NBINS, -1, 0, acc0);
        drive_gate(gb, NBINS, -1, 0, acc1);
        stop_data();
        wait_pv("dir", base + 2);
        if (pv_q.size() >= base + 2) begin
            check_rec("dir.g0", pv_q[base], ga, 0);
            check_rec("dir.g1", pv_q[base+1], gb, 1);
            check("dir.latency_g0", 64'(pv_q[base].cyc), 64'(acc0));
            check("dir.latency_g1", 64'(pv_q[base+1].cyc), 64'(acc1));
            check("dir.spacing", 64'(pv_q[base+1].cyc - pv_q[base].cyc), 64'(NBINS));
            check("dir.done_g0", 64'(pv_q[base].done), 64'(0));
            check("dir.done_g1", 64'(pv_q[base+1].done), 64'(1));
            check("dir.busy_g0", 64'(pv_q[base].busy), 64'(1));
            check("dir.busy_g1", 64'(pv_q[base+1].busy), 64'(1));
        end
        lat_a = (pv_q.size() > base) ? pv_q[base].cyc - t0 : -1;
        // DONE ignores further samples
        drive_gate(rand_gate(), NBINS, -1, 0, acc0);
        drive_gate(rand_gate(), NBINS, -1, 0, acc1);
        stop_data();
        repeat (4) @(negedge clk);
        check("done.no_more_pv", 64'(pv_q.size()), 64'(base + 2));
        check("done.done_count", 64'(done_cnt - dbase), 64'(1));
        check("done.busy", 64'(search_busy), 64'(0));
        go_idle();

        // Same stream with a 5-cycle stall after bin 3
        base = pv_q.size();
        start_profile("gap", t0);
        drive_gate(ga, NBINS, 3, 5, acc0);
        drive_gate(gb, NBINS, -1, 0, acc1);
        stop_data();
        wait_pv("gap", base + 2);
        if (pv_q.size() >= base + 2) begin
            check_rec("gap.g0", pv_q[base], ga, 0);
            check_rec("gap.g1", pv_q[base+1], gb, 1);
            check("gap.delay", 64'(pv_q[base].cyc - t0), 64'(lat_a + 5));
            check("gap.spacing", 64'(pv_q[base+1].cyc - pv_q[base].cyc), 64'(NBINS));
        end
        go_idle();

        // Randomized profiles with random stall placement
        for (int p = 0; p < 6; p++) begin
            g0 = rand_gate(); g1 = rand_gate();
            base = pv_q.size(); dbase = done_cnt;
            start_profile($sformatf("rnd%0d", p), t0);
            drive_gate(g0, NBINS, $urandom_range(0, NBINS), $urandom_range(1, 4), acc0);
            drive_gate(g1, NBINS, $urandom_range(0, NBINS), $urandom_range(1, 4), acc1);
            stop_data();
            wait_pv($sformatf("rnd%0d", p), base + 2);
            if (pv_q.size() >= base + 2) begin
                check_rec($sformatf("rnd%0d.g0", p), pv_q[base], g0, 0);
                check_rec($sformatf("rnd%0d.g1", p), pv_q[base+1], g1, 1);
                check($sformatf("rnd%0d.lat0", p), 64'(pv_q[base].cyc), 64'(acc0));
                check($sformatf("rnd%0d.lat1", p), 64'(pv_q[base+1].cyc), 64'(acc1));
            end
            check($sformatf("rnd%0d.done", p), 64'(done_cnt - dbase), 64'(1));
            go_idle();
        end

        // Abort after bin 5 of gate 1
        g0 = rand_gate(); g1 = rand_gate();
        base = pv_q.size(); dbase = done_cnt;
        start_profile("abort", t0);
        drive_gate(g0, NBINS, -1, 0, acc0);
        drive_gate(g1, 6, -1, 0, acc1);
        @(negedge clk);
        pp_ctrl = 1'b0;
        data_valid_in = 1'b0;
        repeat (20) @(negedge clk);
        ref_peak(g0, idx, v, l, r);
        check("abort.pv_count", 64'(pv_q.size()), 64'(base + 1));
        check("abort.no_done", 64'(done_cnt - dbase), 64'(0));
        check("abort.peak_valid", 64'(peak_valid), 64'(0));
        check("abort.busy", 64'(search_busy), 64'(0));
        check("abort.hold_value", 64'(peak_value), 64'(v));
        check("abort.hold_index", 64'(peak_index), 64'(idx));
        // Restart from gate 0, bin 0
        g0 = rand_gate(); g1 = rand_gate();
        base = pv_q.size(); dbase = done_cnt;
        start_profile("restart", t0);
        drive_gate(g0, NBINS, -1, 0, acc0);
        drive_gate(g1, NBINS, -1, 0, acc1);
        stop_data();
        wait_pv("restart", base + 2);
        if (pv_q.size() >= base + 2) begin
            check_rec("restart.g0", pv_q[base], g0, 0);
            check_rec("restart.g1", pv_q[base+1], g1, 1);
        end
        check("restart.done", 64'(done_cnt - dbase), 64'(1));
        go_idle();

        // Asynchronous reset mid-gate
        start_profile("arst", t0);
        drive_gate(rand_gate(), 3, -1, 0, acc0);
        @(negedge clk);
        rst_n = 1'b0;
        pp_ctrl = 1'b0;
        data_valid_in = 1'b0;
        #1;
        check("arst.peak_valid", 64'(peak_valid), 64'(0));
        check("arst.peak_index", 64'(peak_index), 64'(0));
        check("arst.peak_value", 64'(peak_value), 64'(0));
        check("arst.peak_left",  64'(peak_left),  64'(0));
        check("arst.peak_right", 64'(peak_right), 64'(0));
        check("arst.busy",       64'(search_busy), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        g0 = rand_gate();
        base = pv_q.size();
        start_profile("fresh", t0);
        drive_gate(g0, NBINS, -1, 0, acc0);
        stop_data();
        wait_pv("fresh", base + 1);
        if (pv_q.size() >= base + 1) begin
            check_rec("fresh.g0", pv_q[base], g0, 0);
            check("fresh.latency", 64'(pv_q[base].cyc), 64'(acc0));
        end
        go_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
